pulse_tick_divider: RTL and testbench

Parametrised pulse-to-tick prescaler. Counts qualified input pulses and emits a one-cycle tick every DIV pulses, with a runtime-loadable divisor, periodic or one-shot mode, and a saturating tick tally. Sits between the base timing-pulse generator and the game timers/score logic, replacing fixed divide-by-N counters.

---
 rtl/pulse_tick_divider_if.sv | 31 +++
 rtl/pulse_tick_divider.sv | 136 +++++++++++++
 tb/tb_pulse_tick_divider.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_tick_divider_if.sv
// Bundle of the prescaler's control inputs and status outputs.
// master: the side that drives enable, pulse, mode, arm and divisor loads.
// slave:  the prescaler itself.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = RUN, 2 = DONE.
interface pulse_tick_divider_if #(
    parameter int CNT_W = 8,
    parameter int TOT_W = 16
);
    logic             en;
    logic             pulse;
    logic             mode;
    logic             arm;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             div_err;
    logic [TOT_W-1:0] tick_total;
    logic [1:0]       state_dbg;

    modport master (
        output en, pulse, mode, arm, div_load, div_val,
        input  tick, count, done, div_err, tick_total, state_dbg
    );

    modport slave (
        input  en, pulse, mode, arm, div_load, div_val,
        output tick, count, done, div_err, tick_total, state_dbg
    );
endinterface

// File: rtl/pulse_tick_divider.sv
// Pulse-to-tick prescaler: counts qualified pulses and strobes tick once
// every "divisor" pulses. Periodic or one-shot operation, runtime divisor
// loads (zero is rejected with a div_err strobe), saturating tick tally.
// Handshake: there is no valid/ready pair; every input is sampled on each
// rising clk edge, and every output is a register updated on that edge.
// Optional build macro PULSE_EDGE_EN: pulse goes through a registered
// rising-edge detector, so a held-high pulse counts once and counting lags
// the raw input by one cycle. Without it pulse is counted as a level.
module pulse_tick_divider #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 10,
    parameter int TOT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_tick_divider_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    state_t           state;
    logic             mode_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             done_q;
    logic             err_q;
    logic [TOT_W-1:0] tot_q;

    logic pulse_eff;
    logic load_ok;
    logic load_bad;
    logic terminal;

`ifdef PULSE_EDGE_EN
    logic pulse_prev;
    logic pulse_edge;

    // Registered rising-edge detector on the raw pulse input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_prev <= 1'b0;
            pulse_edge <= 1'b0;
        end else begin
            pulse_prev <= bus.pulse;
            pulse_edge <= bus.pulse & ~pulse_prev;
        end
    end

    assign pulse_eff = pulse_edge;
`else
    assign pulse_eff = bus.pulse;
`endif

    assign load_ok  = bus.div_load && (bus.div_val != '0);
    assign load_bad = bus.div_load && (bus.div_val == '0);
    // Divisor is never zero, so divisor-1 cannot underflow.
    assign terminal = (cnt_q == (div_q - CNT_W'(1)));

    // Control FSM, pulse counter, divisor register and tick tally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            div_q  <= DIV_RST;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            tot_q  <= '0;
        end else begin
            tick_q <= 1'b0;
            err_q  <= load_bad;
            // A valid load always takes effect, even while disabled.
            if (load_ok) begin
                div_q <= bus.div_val;
            end
            if (!bus.en) begin
                state  <= S_IDLE;
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!bus.mode || bus.arm) begin
                            state  <= S_RUN;
                            mode_q <= bus.mode;
                        end
                    end
                    S_RUN: begin
                        // A load restarts the count and swallows this cycle's pulse.
                        if (load_ok) begin
                            cnt_q <= '0;
                        end else if (pulse_eff) begin
                            if (terminal) begin
                                cnt_q  <= '0;
                                tick_q <= 1'b1;
                                if (tot_q != TOT_MAX) begin
                                    tot_q <= tot_q + TOT_W'(1);
                                end
                                if (mode_q) begin
                                    state  <= S_DONE;
                                    done_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        if (bus.arm) begin
                            state  <= S_RUN;
                            done_q <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tick       = tick_q;
    assign bus.count      = cnt_q;
    assign bus.done       = done_q;
    assign bus.div_err    = err_q;
    assign bus.tick_total = tot_q;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_pulse_tick_divider.sv
// Bench for pulse_tick_divider: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model.
module tb_pulse_tick_divider;
    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 10;
    localparam int TOT_W       = 4;
    localparam int TOT_MAX     = (1 << TOT_W) - 1;
`ifdef PULSE_EDGE_EN
    localparam int EDGE = 1;
`else
    localparam int EDGE = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pulse_tick_divider_if #(.CNT_W(CNT_W), .TOT_W(TOT_W)) bus();

    pulse_tick_divider #(
        .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT), .TOT_W(TOT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int pulses_sent = 0;
    int tick_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Status as flags: running / finished; neither means idle.
    bit m_running, m_finished, m_oneshot;
    int m_cnt, m_div, m_tot;
    bit m_tick, m_err;
    bit m_prev, m_edge;

    task automatic model_step();
        bit p;
        bit load_ok;
        if (rst) begin
            m_running = 0; m_finished = 0; m_oneshot = 0;
            m_cnt = 0; m_div = DIV_DEFAULT; m_tot = 0;
            m_tick = 0; m_err = 0; m_prev = 0; m_edge = 0;
            return;
        end
        if (EDGE != 0) begin
            p = m_edge;
            m_edge = bus.pulse && !m_prev;
            m_prev = bus.pulse;
        end else begin
            p = bus.pulse;
        end
        load_ok = bus.div_load && (bus.div_val != 0);
        m_err   = bus.div_load && (bus.div_val == 0);
        m_tick  = 0;
        if (!bus.en) begin
            m_running = 0; m_finished = 0; m_cnt = 0;
        end else if (!m_running && !m_finished) begin
            if (!bus.mode || bus.arm) begin
                m_running = 1;
                m_oneshot = bus.mode;
            end
        end else if (m_finished) begin
            if (bus.arm) begin
                m_finished = 0;
                m_running = 1;
            end
        end else if (load_ok) begin
            m_cnt = 0;
        end else if (p) begin
            m_cnt = (m_cnt + 1) % m_div;
            if (m_cnt == 0) begin
                m_tick = 1;
                m_tot = (m_tot < TOT_MAX) ? m_tot + 1 : TOT_MAX;
                if (m_oneshot) begin
                    m_running = 0;
                    m_finished = 1;
                end
            end
        end
        if (load_ok) m_div = bus.div_val;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("tick", bus.tick, m_tick);
        check("count", bus.count, m_cnt);
        check("done", bus.done, m_finished);
        check("div_err", bus.div_err, m_err);
        check("tick_total", bus.tick_total, m_tot);
        if (bus.tick === 1'b1) tick_log.push_back(pulses_sent);
    endtask

    task automatic pulse_once();
        pulses_sent++;
        bus.pulse = 1'b1;
        cycle();
        bus.pulse = 1'b0;
        cycle();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse_once();
    endtask

    task automatic do_load(input int val);
        bus.div_load = 1'b1;
        bus.div_val  = CNT_W'(val);
        cycle();
        bus.div_load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        bus.en = 0; bus.pulse = 0; bus.mode = 0; bus.arm = 0;
        bus.div_load = 0; bus.div_val = '0;

        rst = 1'b1;
        cycle();
        cycle();
        check("rst_state", bus.state_dbg, 0);
        check("rst_total", bus.tick_total, 0);
        rst = 1'b0;

        // Periodic, default divisor 10, 25 pulses.
        bus.en = 1; bus.mode = 0;
        cycle();
        pulses(25);
        cycle();
        check("p1_ticks", tick_log.size(), 2);
        if (tick_log.size() == 2) begin
            check("p1_tick_a", tick_log[0], 10);
            check("p1_tick_b", tick_log[1], 20);
        end
        check("p1_count", bus.count, 5);
        check("p1_total", bus.tick_total, 2);

        // Divisor load concurrent with a pulse at count 7.
        pulses(2);
        check("ld_pre_count", bus.count, 7);
        bus.pulse = 1;
        pulses_sent++;
        do_load(3);
        bus.pulse = 0;
        check("ld_count", bus.count, 0);
        check("ld_tick", bus.tick, 0);
        cycle();
        check("ld_after", bus.count, EDGE);
        t0 = tick_log.size();
        pulses(3);
        check("ld_div3_ticks", tick_log.size() - t0, 1);
        do_load(0);
        check("err_strobe", bus.div_err, 1);
        cycle();
        check("err_clear", bus.div_err, 0);
        t0 = tick_log.size();
        pulses(3);
        check("err_div_kept", tick_log.size() - t0, 1);

        // One-shot with divisor 3.
        bus.en = 0;
        cycle();
        check("en_off_count", bus.count, 0);
        bus.en = 1; bus.mode = 1;
        cycle();
        pulses(1);
        check("os_idle_count", bus.count, 0);
        bus.arm = 1;
        cycle();
        bus.arm = 0;
        t0 = tick_log.size();
        pulses(3);
        check("os_ticks", tick_log.size() - t0, 1);
        check("os_done", bus.done, 1);
        pulses(3);
        check("os_ignored", tick_log.size() - t0, 1);
        check("os_count", bus.count, 0);
        bus.arm = 1;
        cycle();
        bus.arm = 0;
        check("os_rearm", bus.done, 0);
        pulses(3);
        check("os_ticks2", tick_log.size() - t0, 2);
        check("os_done2", bus.done, 1);

        // Divisor 1, pulse held high for 4 cycles.
        bus.en = 0;
        cycle();
        bus.en = 1; bus.mode = 0;
        do_load(1);
        t0 = tick_log.size();
        bus.pulse = 1;
        repeat (4) cycle();
        bus.pulse = 0;
        repeat (2) cycle();
        check("hold_ticks", tick_log.size() - t0, (EDGE != 0) ? 1 : 4);
        check("hold_total", bus.tick_total, (EDGE != 0) ? 7 : 10);

        // Tally saturation.
        pulses(20);
        check("sat_total", bus.tick_total, TOT_MAX);

        // Reset in the middle of a count.
        rst = 1;
        cycle();
        rst = 0;
        bus.en = 1; bus.mode = 0;
        cycle();
        do_load(8);
        pulses(6);
        check("mid_count", bus.count, 6);
        rst = 1;
        cycle();
        rst = 0;
        check("mr_count", bus.count, 0);
        check("mr_tick", bus.tick, 0);
        check("mr_done", bus.done, 0);
        check("mr_err", bus.div_err, 0);
        check("mr_total", bus.tick_total, 0);
        check("mr_state", bus.state_dbg, 0);
        cycle();
        t0 = tick_log.size();
        pulses(10);
        check("mr_div_default", tick_log.size() - t0, 1);

        // Enable drop mid-run keeps the divisor.
        do_load(5);
        pulses(2);
        check("en_pre_count", bus.count, 2);
        bus.en = 0;
        cycle();
        check("en_drop_count", bus.count, 0);
        check("en_drop_state", bus.state_dbg, 0);
        bus.en = 1;
        cycle();
        t0 = tick_log.size();
        pulses(5);
        check("en_div_kept", tick_log.size() - t0, 1);
        check("en_end_count", bus.count, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.en       = ($urandom_range(0, 24) != 0);
            bus.pulse    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
            bus.arm      = ($urandom_range(0, 9) == 0);
            bus.div_load = ($urandom_range(0, 29) == 0);
            bus.div_val  = CNT_W'($urandom_range(0, 6));
            cycle();
        end
        rst = 0; bus.div_load = 0; bus.pulse = 0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
